// File: rtl/power_ctrl.sv
// power_ctrl: arbitrates power-up touches, tracks player power and
// sequences grow / hurt invincibility windows and death.
module power_ctrl #(
  parameter int                   N_ITEMS     = 4,
  parameter logic [N_ITEMS-1:0]   FLOWER_MASK = 4'b0011,
  parameter int                   ANIM_FRAMES = 8,
  parameter int                   INV_FRAMES  = 60
) (
  input  logic               sys_clk,
  input  logic               RST,
  input  logic               frame_tick,
  input  logic [N_ITEMS-1:0] touch_req,
  input  logic               hit,
  output logic [N_ITEMS-1:0] grant,
  output logic               score_add,
  output logic [1:0]         power,
  output logic               invincible,
  output logic               die
);
  typedef enum logic [1:0] {IDLE, GROW, HURT, DEAD} state_t;
  localparam logic [1:0] SMALL = 2'd0, BIG = 2'd1, FIRE = 2'd2;
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0] INV_LAST  = 8'(INV_FRAMES - 1);
  state_t             r_state;
  logic [N_ITEMS-1:0] r_pending, r_grant;
  logic               r_score, r_inv, r_die, r_apply, r_flower;
  logic [1:0]         r_power;
  logic [7:0]         r_cnt;
  logic [N_ITEMS-1:0] w_pend, w_pick;
  logic [1:0]         w_new_pwr, w_hit_pwr;
  logic               w_grow;
  assign w_pend    = r_pending | touch_req;
  assign w_pick    = w_pend & (~w_pend + 1'b1);
  // r_apply marks the cycle after a grant, when the consumed item takes effect
  assign w_new_pwr = (r_power == SMALL) ? BIG : (r_flower && r_power == BIG) ? FIRE : r_power;
  assign w_grow    = r_apply && (w_new_pwr != r_power);
  assign w_hit_pwr = (r_power == FIRE) ? BIG : SMALL;
  always_ff @(posedge sys_clk) begin
    if (RST) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_grant   <= '0;
      r_score   <= 1'b0;
      r_inv     <= 1'b0;
      r_die     <= 1'b0;
      r_apply   <= 1'b0;
      r_flower  <= 1'b0;
      r_power   <= SMALL;
      r_cnt     <= '0;
    end else begin
      r_grant   <= '0;
      r_score   <= 1'b0;
      r_die     <= 1'b0;
      r_apply   <= 1'b0;
      r_pending <= w_pend;
      case (r_state)
        IDLE: begin
          if (w_grow) begin
            r_power <= w_new_pwr;
            r_state <= GROW;
            r_inv   <= 1'b1;
            r_cnt   <= '0;
          end else if (hit) begin
            if (r_power == SMALL) begin
              r_state <= DEAD;
              r_die   <= 1'b1;
            end else begin
              r_power <= w_hit_pwr;
              r_state <= HURT;
              r_inv   <= 1'b1;
              r_cnt   <= '0;
            end
          end else if (!r_apply && |w_pend) begin
            r_grant   <= w_pick;
            r_score   <= 1'b1;
            r_apply   <= 1'b1;
            r_flower  <= |(w_pick & FLOWER_MASK);
            r_pending <= w_pend & ~w_pick;
          end
        end
        GROW, HURT: begin
          if (frame_tick) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt == ((r_state == GROW) ? ANIM_LAST : INV_LAST)) begin
              r_state <= IDLE;
              r_inv   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
  assign grant      = r_grant;
  assign score_add  = r_score;
  assign power      = r_power;
  assign invincible = r_inv;
  assign die        = r_die;
endmodule

// File: tb/tb_power_ctrl.sv
// tb_power_ctrl: table-driven vectors plus hand sequences for death and reset.
module tb_power_ctrl;
  logic       sys_clk = 1'b0;
  logic       RST = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] touch_req = '0;
  logic       hit = 1'b0;
  logic [3:0] grant;
  logic       score_add;
  logic [1:0] power;
  logic       invincible;
  logic       die;
  int         n_cmp = 0;
  int         n_bad = 0;

  power_ctrl dut (
    .sys_clk(sys_clk), .RST(RST), .frame_tick(frame_tick), .touch_req(touch_req),
    .hit(hit), .grant(grant), .score_add(score_add), .power(power),
    .invincible(invincible), .die(die)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst, tick;
    logic [3:0] touch;
    logic       hit;
    logic [3:0] g;
    logic       s;
    logic [1:0] p;
    logic       i, d;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rst, tick, input logic [3:0] touch, input logic h,
                     input logic [3:0] g, input logic s, input logic [1:0] p,
                     input logic i, d);
    vq.push_back('{rst, tick, touch, h, g, s, p, i, d});
  endtask

  task automatic chk(input string name, input logic [3:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, tick, input logic [3:0] touch, input logic h);
    RST = rst; frame_tick = tick; touch_req = touch; hit = h;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic s,
                         input logic [1:0] p, input logic i, d);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".score"}, {3'b0, score_add}, {3'b0, s});
    chk({tag, ".power"}, {2'b0, power}, {2'b0, p});
    chk({tag, ".inv"}, {3'b0, invincible}, {3'b0, i});
    chk({tag, ".die"}, {3'b0, die}, {3'b0, d});
  endtask

  initial begin
    // reset, mushroom from SMALL grows to BIG; tick on entry cycle not counted
    add(1,0,4'b0000,0, 4'b0000,0,0,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,0,0,0);
    add(0,0,4'b0100,0, 4'b0100,1,0,0,0);
    add(0,1,4'b0000,0, 4'b0000,0,1,1,0);
    for (int k = 0; k < 7; k++) add(0,1,4'b0000,0, 4'b0000,0,1,1,0);
    add(0,1,4'b0000,0, 4'b0000,0,1,0,0);
    // mushroom at BIG: grant, no change, no GROW
    add(0,0,4'b1000,0, 4'b1000,1,1,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,1,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,1,0,0);
    // 1010 at BIG: flower item1 first -> FIRE/GROW, item3 after GROW
    add(0,0,4'b1010,0, 4'b0010,1,1,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,2,1,0);
    for (int k = 0; k < 7; k++) add(0,1,4'b0000,0, 4'b0000,0,2,1,0);
    add(0,1,4'b0000,0, 4'b0000,0,2,0,0);
    add(0,0,4'b0000,0, 4'b1000,1,2,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,2,0,0);
    // two no-change grants are spaced two cycles apart
    add(0,0,4'b1100,0, 4'b0100,1,2,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,2,0,0);
    add(0,0,4'b0000,0, 4'b1000,1,2,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,2,0,0);
    // FIRE hit beats touch; second hit ignored; touches accumulate in HURT
    add(0,0,4'b0100,1, 4'b0000,0,1,1,0);
    for (int k = 0; k < 9; k++) add(0,1,4'b0000,0, 4'b0000,0,1,1,0);
    add(0,1,4'b0000,1, 4'b0000,0,1,1,0);
    add(0,0,4'b0001,0, 4'b0000,0,1,1,0);
    for (int k = 0; k < 49; k++) add(0,1,4'b0000,0, 4'b0000,0,1,1,0);
    add(0,1,4'b0000,0, 4'b0000,0,1,0,0);
    add(0,0,4'b0000,0, 4'b0001,1,1,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,2,1,0);
    // BIG hit drops to SMALL
    add(1,0,4'b0000,0, 4'b0000,0,0,0,0);
    add(0,0,4'b0001,0, 4'b0001,1,0,0,0);
    add(0,0,4'b0000,0, 4'b0000,0,1,1,0);
    for (int k = 0; k < 8; k++) add(0,1,4'b0000,0, 4'b0000,0,1,k < 7,0);
    add(0,0,4'b0000,1, 4'b0000,0,0,1,0);

    for (int v = 0; v < vq.size(); v++) begin
      step(vq[v].rst, vq[v].tick, vq[v].touch, vq[v].hit);
      chk_all($sformatf("vec%0d", v), vq[v].g, vq[v].s, vq[v].p, vq[v].i, vq[v].d);
    end

    // SMALL flower: grant then power BIG, invincible for exactly 8 ticks
    step(1,0,4'b0000,0);
    step(0,0,4'b0001,0);
    chk_all("flw.grant", 4'b0001, 1, 0, 0, 0);
    step(0,0,4'b0000,0);
    chk_all("flw.apply", 4'b0000, 0, 1, 1, 0);
    for (int k = 0; k < 8; k++) begin
      step(0,0,4'b0000,0);
      chk_all($sformatf("flw.gap%0d", k), 4'b0000, 0, 1, 1, 0);
      step(0,1,4'b0000,0);
      chk_all($sformatf("flw.tick%0d", k), 4'b0000, 0, 1, k < 7, 0);
    end

    // reset mid-GROW with a pending touch discards everything
    step(1,0,4'b0000,0);
    step(0,0,4'b0001,0);
    step(0,0,4'b0000,0);
    step(0,1,4'b0100,0);
    chk_all("rst.grow", 4'b0000, 0, 1, 1, 0);
    step(1,0,4'b0000,0);
    chk_all("rst.now", 4'b0000, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0,0,4'b0000,0);
      chk_all($sformatf("rst.after%0d", k), 4'b0000, 0, 0, 0, 0);
    end

    // SMALL hit with simultaneous touch: die, DEAD forever
    step(0,0,4'b0001,1);
    chk_all("dead.entry", 4'b0000, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      step(0, k[0], 4'(1 << (k % 4)), k == 2);
      chk_all($sformatf("dead.hold%0d", k), 4'b0000, 0, 0, 0, 0);
    end
    step(1,0,4'b0000,0);
    step(0,0,4'b0000,0);
    chk_all("dead.cleared", 4'b0000, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
